// File: rtl/seq_shifter_if.sv
// Handshake and data bundle for seq_shifter: operands and start in, busy/done/result out.
interface seq_shifter_if #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
);
    logic             start;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   shamt;
    logic             dir;
    logic             arith;
    logic             rot;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out_data;

    modport master (
        output start, in_data, shamt, dir, arith, rot,
        input  busy, done, out_data
    );

    modport slave (
        input  start, in_data, shamt, dir, arith, rot,
        output busy, done, out_data
    );
endinterface

// File: rtl/seq_shifter.sv
// Sequential one-bit-per-cycle shifter with IDLE/SHIFT/DONE control.
// Optional rotate support is enabled by defining SEQ_SHIFTER_ROTATE_EN.
module seq_shifter #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_shifter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   cnt;
    logic             dirq;
    logic             arithq;
`ifdef SEQ_SHIFTER_ROTATE_EN
    logic             rotq;
`endif
    logic [WIDTH-1:0] stepped;
    logic             fill_l;
    logic             fill_r;

    // One-position step of the working register; rotate wins over sign fill.
    always_comb begin
        fill_l  = 1'b0;
        fill_r  = arithq ? work[WIDTH-1] : 1'b0;
`ifdef SEQ_SHIFTER_ROTATE_EN
        if (rotq) begin
            fill_l = work[WIDTH-1];
            fill_r = work[0];
        end
`endif
        stepped = dirq ? {fill_r, work[WIDTH-1:1]} : {work[WIDTH-2:0], fill_l};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            work         <= '0;
            cnt          <= '0;
            dirq         <= 1'b0;
            arithq       <= 1'b0;
`ifdef SEQ_SHIFTER_ROTATE_EN
            rotq         <= 1'b0;
`endif
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.out_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        work   <= bus.in_data;
                        cnt    <= bus.shamt;
                        dirq   <= bus.dir;
                        arithq <= bus.arith;
`ifdef SEQ_SHIFTER_ROTATE_EN
                        rotq   <= bus.rot;
`endif
                        if (bus.shamt != '0) begin
                            state    <= SHIFT;
                            bus.busy <= 1'b1;
                        end else begin
                            state        <= DONE;
                            bus.done     <= 1'b1;
                            bus.out_data <= bus.in_data;
                        end
                    end
                end
                SHIFT: begin
                    work <= stepped;
                    cnt  <= cnt - SHW'(1);
                    // The edge applying the last step also publishes the result.
                    if (cnt == SHW'(1)) begin
                        state        <= DONE;
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        bus.out_data <= stepped;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed self-checking bench for seq_shifter; expected rotate result
// follows whether SEQ_SHIFTER_ROTATE_EN is defined for the build.
module tb_seq_shifter;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    seq_shifter_if #(.WIDTH(8), .SHW(3)) bus ();

    seq_shifter #(.WIDTH(8), .SHW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Presents operands with start for exactly one rising edge.
    task automatic applyStimulus(input logic [7:0] d, input logic [2:0] s,
                                 input logic dr, input logic ar, input logic rt);
        @(negedge clk);
        bus.in_data = d;
        bus.shamt   = s;
        bus.dir     = dr;
        bus.arith   = ar;
        bus.rot     = rt;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    // Counts busy cycles (sampled at negedges) until done, bounded.
    task automatic waitDone(output int busyCycles, output logic seen);
        busyCycles = 0;
        seen       = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) busyCycles++;
            @(negedge clk);
        end
    endtask

    task automatic runOp(input string tag, input logic [7:0] d, input logic [2:0] s,
                         input logic dr, input logic ar, input logic rt, input logic [7:0] expOut);
        int   bc;
        logic seen;
        applyStimulus(d, s, dr, ar, rt);
        waitDone(bc, seen);
        checkOutput({tag, "_done"}, 32'(seen), 32'd1);
        checkOutput({tag, "_busycycles"}, 32'(bc), 32'(s));
        checkOutput({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, "_out"}, 32'(bus.out_data), 32'(expOut));
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        checkOutput({tag, "_out_held"}, 32'(bus.out_data), 32'(expOut));
    endtask

    initial begin
        int   bc;
        logic seen;
        logic doneSeen;
        logic [7:0] rotExp;

        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.in_data = 8'h00;
        bus.shamt   = 3'd0;
        bus.dir     = 1'b0;
        bus.arith   = 1'b0;
        bus.rot     = 1'b0;

        #12;
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        checkOutput("reset_out", 32'(bus.out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        runOp("left3", 8'h96, 3'd3, 1'b0, 1'b0, 1'b0, 8'hB0);
        runOp("asr2", 8'h96, 3'd2, 1'b1, 1'b1, 1'b0, 8'hE5);
        runOp("lsr2", 8'h96, 3'd2, 1'b1, 1'b0, 1'b0, 8'h25);
        runOp("lsr7", 8'h96, 3'd7, 1'b1, 1'b0, 1'b0, 8'h01);
        runOp("asr7", 8'h96, 3'd7, 1'b1, 1'b1, 1'b0, 8'hFF);
        runOp("left_arith_ignored", 8'hC3, 3'd1, 1'b0, 1'b1, 1'b0, 8'h86);
        runOp("zero_shift", 8'h5A, 3'd0, 1'b0, 1'b0, 1'b0, 8'h5A);

`ifdef SEQ_SHIFTER_ROTATE_EN
        rotExp = 8'hC0;
`else
        rotExp = 8'h40;
`endif
        runOp("rot_right1", 8'h81, 3'd1, 1'b1, 1'b0, 1'b1, rotExp);

        // Start re-pulsed with new operands during SHIFT must be ignored.
        applyStimulus(8'h96, 3'd3, 1'b0, 1'b0, 1'b0);
        checkOutput("ignore_busy_first", 32'(bus.busy), 32'd1);
        bus.in_data = 8'h5A;
        bus.shamt   = 3'd1;
        bus.dir     = 1'b1;
        bus.arith   = 1'b1;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        waitDone(bc, seen);
        checkOutput("ignore_done", 32'(seen), 32'd1);
        checkOutput("ignore_busycycles", 32'(bc + 1), 32'd3);
        checkOutput("ignore_out", 32'(bus.out_data), 32'hB0);
        @(negedge clk);
        checkOutput("ignore_no_queue_busy", 32'(bus.busy), 32'd0);
        checkOutput("ignore_no_queue_done", 32'(bus.done), 32'd0);

        // Reset asserted mid-SHIFT aborts with no done pulse.
        applyStimulus(8'h96, 3'd3, 1'b0, 1'b0, 1'b0);
        checkOutput("abort_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out", 32'(bus.out_data), 32'd0);
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        doneSeen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) doneSeen = 1'b1;
        end
        checkOutput("abort_no_done", 32'(doneSeen), 32'd0);
        runOp("after_abort", 8'h96, 3'd3, 1'b0, 1'b0, 1'b0, 8'hB0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001: Parameter WIDTH, default 8: data width in bits; fixed at 8 for this release.
REQ-002: Parameter SHW, default 3: shift-amount width, equal to log2(WIDTH).
REQ-003: clk  input  1  single clock; all state updates on its rising edge.
REQ-004: rst_n  input  1  reset, asynchronous, active-low.
REQ-005: start  input  1  request strobe; sampled only in IDLE.
REQ-006: in_data  input  WIDTH  operand, captured on an accepted start.
REQ-007: shamt  input  SHW  shift count 0..7, captured on an accepted start.
REQ-008: dir  input  1  direction: 0 = left, 1 = right; captured on an accepted start.
REQ-009: arith  input  1  right-shift fill: 1 = sign fill, 0 = zero fill; ignored for left shifts; captured on an accepted start.
REQ-010: rot  input  1  rotate request; captured on an accepted start; honoured only per REQ-030.
REQ-011: busy  output  1  high while shifting.
REQ-012: done  output  1  one-cycle completion pulse.
REQ-013: out_data  output  WIDTH  result register.

Function
REQ-014: The FSM SHALL have exactly the states IDLE, SHIFT and DONE.
REQ-015: In IDLE with start=1, the block SHALL latch in_data, shamt, dir, arith and rot into internal registers, then move to SHIFT if shamt!=0, else to DONE.
REQ-016: In SHIFT, each cycle SHALL shift the working register by one position in the latched direction and decrement the counter.
REQ-017: SHIFT SHALL move to DONE on the edge that applies the final (shamt-th) shift.
REQ-018: Left shifts SHALL fill the LSB with 0.
REQ-019: Right shifts SHALL fill the MSB with the current MSB when arith=1, and with 0 when arith=0.
REQ-020: busy SHALL be 1 exactly while in SHIFT; for shamt=k>=1, busy is high for k cycles following the start edge.
REQ-021: done SHALL be 1 exactly while in DONE (one cycle); DONE SHALL always return to IDLE on the next edge.
REQ-022: out_data SHALL be updated with the final result on entry to DONE and held until the next result is written.
REQ-023: Total latency from the start edge to done=1 SHALL be shamt+1 cycles; for shamt=0, out_data equals in_data.
REQ-024: start asserted in SHIFT or DONE SHALL be ignored, with no queuing.
REQ-025: Changes on in_data, shamt, dir, arith or rot after acceptance SHALL NOT affect the operation in progress.

Reset
REQ-026: When rst_n=0, the block SHALL force IDLE, busy=0, done=0, out_data=0, and clear all internal registers, independent of clk.
REQ-027: A reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-028: After rst_n deasserts, the first accepted start SHALL behave exactly as from power-up.

Configuration
REQ-029: The macro SEQ_SHIFTER_ROTATE_EN SHALL control rotate support.
REQ-030: With SEQ_SHIFTER_ROTATE_EN defined, latched rot=1 SHALL make each step a rotate (the bit shifted out re-enters at the opposite end), and rot SHALL take priority over arith.
REQ-031: Without SEQ_SHIFTER_ROTATE_EN, the rot port SHALL remain present but be ignored (treated as 0); no rotate logic is synthesised.

Verification
REQ-032: in_data=8'h96, shamt=3, dir=0 -> busy high 3 cycles, then done=1 with out_data=8'hB0.
REQ-033: in_data=8'h96, shamt=2, dir=1, arith=1 -> out_data=8'hE5; same stimulus with arith=0 -> 8'h25; shamt=7, arith=0 -> 8'h01.
REQ-034: in_data=8'h5A, shamt=0 -> busy never high, done=1 on the cycle after the start edge, out_data=8'h5A.
REQ-035: in_data=8'h81, shamt=1, dir=1, rot=1 -> 8'hC0 with SEQ_SHIFTER_ROTATE_EN defined, 8'h40 without it.
REQ-036: start re-pulsed with new operands during SHIFT -> ignored, and the original result is delivered; rst_n pulled low during SHIFT -> out_data=0, busy=0, no done, and the next start completes normally.
